bus_master_watchdog: RTL
========================

# bus_master_watchdog

Transaction guard between the CPU adapter's bus-master port and the bus matrix. It registers each master request, drives it onto the matrix, and bounds its duration with a cycle watchdog. It returns read data, completion, slave errors and timeouts to the master with sticky error reporting until the master asserts error-clear. It also keeps saturating transaction and timeout statistics.

## Interface
- `ADDR_W`, default `` `VTX1_ADDR_WIDTH ``: address width.
- `WORD_W`, default `` `VTX1_WORD_WIDTH ``: data width.
- `TIMEOUT_CYCLES`, default 32: maximum cycles `s_req` stays high before a timeout is declared. Legal values are 2..256.
- `CNT_W`, default `$clog2(TIMEOUT_CYCLES)`: watchdog counter width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, **synchronous, active-low**.
- `m_req`, `m_wr`, `m_size[1:0]`, `m_addr[ADDR_W]`, `m_wdata[WORD_W]` in: master request fields.
- `m_rdata` out WORD_W: read data.
- `m_ready` out 1: one-cycle completion pulse.
- `m_error` out 1: sticky slave error.
- `m_error_code` out 4: latched error code.
- `m_timeout` out 1: sticky watchdog timeout.
- `m_error_clear` in 1: releases FAULT.
- `s_req`, `s_wr`, `s_size[1:0]`, `s_addr[ADDR_W]`, `s_wdata[WORD_W]` out: request to the bus matrix.
- `s_rdata` in WORD_W, `s_ready` in 1, `s_error` in 1, `s_error_code` in 4: matrix response.
- `busy` out 1: state ≠ IDLE.
- `txn_count` out 16: successful completions, saturating.
- `timeout_count` out 8: timeouts, saturating.
- `last_err_addr` out ADDR_W: address of the last failed transaction.

## Operation
- States are IDLE, ISSUE, RESP and FAULT, all registered.
- **IDLE**
  - `s_req` = 0.
  - If `m_req` = 1, capture `m_wr`, `m_size`, `m_addr` and `m_wdata` into hold registers, clear the watchdog counter, and go to ISSUE.
- **ISSUE**
  - `s_req` = 1. `s_*` fields come from the hold registers and are stable for the whole of ISSUE; later master field changes are ignored.
  - Priority per cycle:
    1. `s_error`: latch `s_error_code` into `m_error_code`, set `m_error`, record `last_err_addr`, go to FAULT.
    2. `s_ready`: if the held `wr` = 0, capture `s_rdata` into `m_rdata`; for writes `m_rdata` is unchanged. Go to RESP.
    3. Counter == `TIMEOUT_CYCLES`-1: set `m_timeout`, `m_error_code` = `` `VTX1_BUS_ERR_TIMEOUT `` (4'hE), record `last_err_addr`, increment `timeout_count`, go to FAULT.
    4. Otherwise increment the counter.
  - Simultaneous `s_error` and `s_ready`: error wins. `s_ready` in the final watchdog cycle: ready wins, no timeout.
- **RESP**
  - `m_ready` = 1 for exactly this cycle, `s_req` = 0, `txn_count`++ (saturates at 16'hFFFF).
  - Next state is IDLE, never directly ISSUE. Back-to-back requests therefore have one idle bubble.
- **FAULT**
  - `s_req` = 0, `m_ready` = 0. `m_error` / `m_timeout` / `m_error_code` are held.
  - On `m_error_clear` = 1: clear `m_error`, `m_timeout` and `m_error_code`, go to IDLE. `m_req` in that same cycle is not accepted; it is sampled again in IDLE.
  - `m_req` without clear is ignored.
- **Response-field retention**: `m_error_code` and `m_rdata` hold their value until overwritten; `last_err_addr` is never cleared by `m_error_clear`.
- **Reset values** (state IDLE, watchdog counter 0):
  - Zero: `s_req`, `s_wr`, `s_size`, `s_addr`, `s_wdata`, `m_ready`, `m_error`, `m_error_code`, `m_timeout`, `m_rdata`, `busy`, `txn_count`, `timeout_count`, `last_err_addr`.
- **Reset mid-transaction**: `s_req` drops the cycle after `rst_n` is sampled low. Nothing is reported to the master.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Read/write with `m_req` sampled at edge 0:
  - `s_req` is high from cycle 1.
  - `s_ready` sampled at edge k puts the block in RESP, with `m_ready` and `m_rdata` valid in cycle k+1.
  - Minimum request-to-`m_ready` latency is 2 cycles (`s_ready` present in cycle 1).
- Timeout: with no response, `s_req` is high for exactly `TIMEOUT_CYCLES` cycles (cycles 1..T). `m_timeout` rises in cycle T+1.
- Error: `s_error` sampled at edge k gives `m_error` in cycle k+1.
- FAULT→IDLE takes one cycle after `m_error_clear` is sampled. The earliest subsequent `s_req` is 2 cycles after the clear.
- Master contract: hold `m_req` until `m_ready`, or until `m_error`/`m_timeout` is seen.

## Structure
- **`vtx1_state_constants.v`**: state encodings. IDLE = `` `VTX1_STATE_IDLE ``, ISSUE = `` `VTX1_STATE_ACTIVE ``, RESP = `` `VTX1_STATE_WAIT ``, FAULT = `` `VTX1_STATE_ERROR ``.
- **`vtx1_error_macros.v`**: add `` `VTX1_BUS_ERR_TIMEOUT `` = 4'hE.
- **Sub-module `vtx1_sat_counter`** (params WIDTH; ports `clk`, `rst_n`, `inc`, `count`): instantiated for `txn_count` and `timeout_count`.
- The watchdog counter stays inline.

## Test plan
- **Read**: `m_req`=1, `m_wr`=0, `m_addr`=0x100; slave `s_ready` in cycle 3 with `s_rdata`=0x1234 → `m_ready` pulses in cycle 4 with `m_rdata`=0x1234, `txn_count`=1, `s_req` high cycles 1–3 only.
- **Write**: `m_wdata`=0xABC, with `m_wdata` changed to 0 while in ISSUE → `s_wdata` stays 0xABC until `s_ready`; `m_rdata` unchanged.
- **Timeout**: `TIMEOUT_CYCLES`=8, slave silent → `s_req` high for 8 cycles, `m_timeout`=1 and `m_error_code`=4'hE in cycle 9, `timeout_count`=1, `last_err_addr`=request address. Pulse `m_error_clear` together with `m_req` → no `s_req` that cycle; `s_req` goes high 2 cycles after the clear.
- **Error priority**: `s_error`=1, `s_ready`=1, `s_error_code`=4'h3 in the same cycle → `m_error`=1, code 3, no `m_ready`, `txn_count` unchanged. Separately, `s_ready` in watchdog cycle T → completion, no timeout.
- **Reset mid-ISSUE**: `rst_n`=0 for one cycle → `s_req`=0 next cycle, all outputs at reset values, no `m_ready`.
- **Saturation**: preload `txn_count` to 16'hFFFF via 65535 forced completions (or a `vtx1_sat_counter` unit test) → it stays at 16'hFFFF after one more completion.

Source files
------------

// File: rtl/bus_master_watchdog_pkg.sv
// Shared types and constants for the bus-master transaction guard.
package bus_master_watchdog_pkg;

    localparam int unsigned VTX1_ADDR_WIDTH = 32;
    localparam int unsigned VTX1_WORD_WIDTH = 32;
    localparam int unsigned ERR_CODE_W      = 4;
    localparam int unsigned TXN_CNT_W       = 16;
    localparam int unsigned TMO_CNT_W       = 8;

    localparam logic [ERR_CODE_W-1:0] VTX1_BUS_ERR_TIMEOUT = 4'hE;

    // IDLE/ACTIVE/WAIT/ERROR map onto IDLE/ISSUE/RESP/FAULT
    typedef enum logic [1:0] {
        VTX1_STATE_IDLE   = 2'd0,
        VTX1_STATE_ACTIVE = 2'd1,
        VTX1_STATE_WAIT   = 2'd2,
        VTX1_STATE_ERROR  = 2'd3
    } bmw_state_e;

endpackage

// File: rtl/vtx1_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module vtx1_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bus_master_watchdog.sv
// Registers master requests onto the bus matrix, bounds each one with a cycle
// watchdog and reports completion, sticky slave errors and timeouts.
module bus_master_watchdog
    import bus_master_watchdog_pkg::*;
#(
    parameter int unsigned ADDR_W         = VTX1_ADDR_WIDTH,
    parameter int unsigned WORD_W         = VTX1_WORD_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m_req,
    input  logic                  m_wr,
    input  logic [1:0]            m_size,
    input  logic [ADDR_W-1:0]     m_addr,
    input  logic [WORD_W-1:0]     m_wdata,
    output logic [WORD_W-1:0]     m_rdata,
    output logic                  m_ready,
    output logic                  m_error,
    output logic [ERR_CODE_W-1:0] m_error_code,
    output logic                  m_timeout,
    input  logic                  m_error_clear,

    output logic                  s_req,
    output logic                  s_wr,
    output logic [1:0]            s_size,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [WORD_W-1:0]     s_wdata,
    input  logic [WORD_W-1:0]     s_rdata,
    input  logic                  s_ready,
    input  logic                  s_error,
    input  logic [ERR_CODE_W-1:0] s_error_code,

    output logic                  busy,
    output logic [TXN_CNT_W-1:0]  txn_count,
    output logic [TMO_CNT_W-1:0]  timeout_count,
    output logic [ADDR_W-1:0]     last_err_addr
);

    bmw_state_e state_q, state_d;

    logic [CNT_W-1:0]      wd_q, wd_d;
    logic                  s_req_q, s_req_d;
    logic                  s_wr_q, s_wr_d;
    logic [1:0]            s_size_q, s_size_d;
    logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
    logic [WORD_W-1:0]     s_wdata_q, s_wdata_d;
    logic [WORD_W-1:0]     m_rdata_q, m_rdata_d;
    logic                  m_ready_q, m_ready_d;
    logic                  m_error_q, m_error_d;
    logic [ERR_CODE_W-1:0] m_error_code_q, m_error_code_d;
    logic                  m_timeout_q, m_timeout_d;
    logic                  busy_q, busy_d;
    logic [ADDR_W-1:0]     last_err_addr_q, last_err_addr_d;

    logic                  wd_last_c;
    logic                  txn_inc_c;
    logic                  tmo_inc_c;

    assign wd_last_c = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= VTX1_STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: error beats ready, ready beats the final watchdog cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            VTX1_STATE_IDLE: begin
                if (m_req) state_d = VTX1_STATE_ACTIVE;
            end
            VTX1_STATE_ACTIVE: begin
                if (s_error)        state_d = VTX1_STATE_ERROR;
                else if (s_ready)   state_d = VTX1_STATE_WAIT;
                else if (wd_last_c) state_d = VTX1_STATE_ERROR;
            end
            VTX1_STATE_WAIT: begin
                state_d = VTX1_STATE_IDLE;
            end
            VTX1_STATE_ERROR: begin
                if (m_error_clear) state_d = VTX1_STATE_IDLE;
            end
            default: state_d = VTX1_STATE_IDLE;
        endcase
    end

    // Output/datapath next values; strobes derive from the upcoming state
    always_comb begin
        wd_d            = wd_q;
        s_wr_d          = s_wr_q;
        s_size_d        = s_size_q;
        s_addr_d        = s_addr_q;
        s_wdata_d       = s_wdata_q;
        m_rdata_d       = m_rdata_q;
        m_error_d       = m_error_q;
        m_error_code_d  = m_error_code_q;
        m_timeout_d     = m_timeout_q;
        last_err_addr_d = last_err_addr_q;
        txn_inc_c       = 1'b0;
        tmo_inc_c       = 1'b0;

        case (state_q)
            VTX1_STATE_IDLE: begin
                if (m_req) begin
                    s_wr_d    = m_wr;
                    s_size_d  = m_size;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    wd_d      = '0;
                end
            end
            VTX1_STATE_ACTIVE: begin
                if (s_error) begin
                    m_error_d       = 1'b1;
                    m_error_code_d  = s_error_code;
                    last_err_addr_d = s_addr_q;
                end else if (s_ready) begin
                    if (!s_wr_q) m_rdata_d = s_rdata;
                    txn_inc_c = 1'b1;
                end else if (wd_last_c) begin
                    m_timeout_d     = 1'b1;
                    m_error_code_d  = VTX1_BUS_ERR_TIMEOUT;
                    last_err_addr_d = s_addr_q;
                    tmo_inc_c       = 1'b1;
                end else begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            VTX1_STATE_ERROR: begin
                if (m_error_clear) begin
                    m_error_d      = 1'b0;
                    m_timeout_d    = 1'b0;
                    m_error_code_d = '0;
                end
            end
            default: ;
        endcase

        s_req_d   = (state_d == VTX1_STATE_ACTIVE);
        m_ready_d = (state_d == VTX1_STATE_WAIT);
        busy_d    = (state_d != VTX1_STATE_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q            <= '0;
            s_req_q         <= 1'b0;
            s_wr_q          <= 1'b0;
            s_size_q        <= '0;
            s_addr_q        <= '0;
            s_wdata_q       <= '0;
            m_rdata_q       <= '0;
            m_ready_q       <= 1'b0;
            m_error_q       <= 1'b0;
            m_error_code_q  <= '0;
            m_timeout_q     <= 1'b0;
            busy_q          <= 1'b0;
            last_err_addr_q <= '0;
        end else begin
            wd_q            <= wd_d;
            s_req_q         <= s_req_d;
            s_wr_q          <= s_wr_d;
            s_size_q        <= s_size_d;
            s_addr_q        <= s_addr_d;
            s_wdata_q       <= s_wdata_d;
            m_rdata_q       <= m_rdata_d;
            m_ready_q       <= m_ready_d;
            m_error_q       <= m_error_d;
            m_error_code_q  <= m_error_code_d;
            m_timeout_q     <= m_timeout_d;
            busy_q          <= busy_d;
            last_err_addr_q <= last_err_addr_d;
        end
    end

    // Counters update on the same edge as the completion/timeout they record
    vtx1_sat_counter #(.WIDTH(TXN_CNT_W)) u_txn_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (txn_inc_c),
        .count (txn_count)
    );

    vtx1_sat_counter #(.WIDTH(TMO_CNT_W)) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (tmo_inc_c),
        .count (timeout_count)
    );

    assign s_req         = s_req_q;
    assign s_wr          = s_wr_q;
    assign s_size        = s_size_q;
    assign s_addr        = s_addr_q;
    assign s_wdata       = s_wdata_q;
    assign m_rdata       = m_rdata_q;
    assign m_ready       = m_ready_q;
    assign m_error       = m_error_q;
    assign m_error_code  = m_error_code_q;
    assign m_timeout     = m_timeout_q;
    assign busy          = busy_q;
    assign last_err_addr = last_err_addr_q;

endmodule
